// File: rtl/mc14500b_pkg.sv
// Shared opcode definitions for the MC14500B-family industrial control units.
package mc14500b_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t NOPO_INST = 4'h0;
    localparam opcode_t LD_INST   = 4'h1;
    localparam opcode_t LDC_INST  = 4'h2;
    localparam opcode_t AND_INST  = 4'h3;
    localparam opcode_t ANDC_INST = 4'h4;
    localparam opcode_t OR_INST   = 4'h5;
    localparam opcode_t ORC_INST  = 4'h6;
    localparam opcode_t XNOR_INST = 4'h7;
    localparam opcode_t STO_INST  = 4'h8;
    localparam opcode_t STOC_INST = 4'h9;
    localparam opcode_t IEN_INST  = 4'hA;
    localparam opcode_t OEN_INST  = 4'hB;
    localparam opcode_t JMP_INST  = 4'hC;
    localparam opcode_t RTN_INST  = 4'hD;
    localparam opcode_t SKZ_INST  = 4'hE;
    localparam opcode_t NOPF_INST = 4'hF;

endpackage

// File: rtl/mc14500b_wide_lu.sv
// Bitwise logic unit: computes the next result register from opcode, RR and operand.
// Opcodes that do not touch RR pass it through unchanged.
module mc14500b_wide_lu
    import mc14500b_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        i_ir,
    input  logic [DATA_W-1:0] i_rr,
    input  logic [DATA_W-1:0] i_opd,
    output logic [DATA_W-1:0] o_rr_nxt
);

    // Decode the logic opcodes; everything else holds RR.
    always_comb begin
        o_rr_nxt = i_rr;
        case (i_ir)
            LD_INST:   o_rr_nxt = i_opd;
            LDC_INST:  o_rr_nxt = ~i_opd;
            AND_INST:  o_rr_nxt = i_rr & i_opd;
            ANDC_INST: o_rr_nxt = i_rr & ~i_opd;
            OR_INST:   o_rr_nxt = i_rr | i_opd;
            ORC_INST:  o_rr_nxt = i_rr | ~i_opd;
            XNOR_INST: o_rr_nxt = ~(i_rr ^ i_opd);
            default:   o_rr_nxt = i_rr;
        endcase
    end

endmodule

// File: rtl/mc14500b_wide_icu.sv
// Word-wide MC14500B industrial control unit. An instruction occupies CYC_PER_INST clocks:
// opcode and operand are captured at the end of phase 0, and every output updates together at
// the end of the last phase, holding until the next commit.
module mc14500b_wide_icu
    import mc14500b_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CYC_PER_INST = 2,
    localparam int unsigned PH_W        = $clog2(CYC_PER_INST)
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [3:0]        I,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic [DATA_W-1:0] RR,
    output logic              FLGO,
    output logic              FLGF,
    output logic              JMP,
    output logic              RTN,
    output logic              SKP,
    output logic              ien_out,
    output logic              oen_out,
    output logic [PH_W-1:0]   state_out
);

    localparam logic [PH_W-1:0] LastPh = PH_W'(CYC_PER_INST - 1);

    // Phase counter and edge qualifiers
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic              w_sample;
    logic              w_commit;

    // Captured instruction
    logic [3:0]        r_ir;
    logic [DATA_W-1:0] r_opd;
    logic              r_d0;     // raw data_in[0]; IEN/OEN ignore the input-enable gate
    logic              r_sq;     // this instruction is being squashed

    // Architectural state and output registers
    logic [DATA_W-1:0] r_rr;
    logic [DATA_W-1:0] r_dout;
    logic              r_write;
    logic              r_flgo;
    logic              r_flgf;
    logic              r_jmp;
    logic              r_rtn;
    logic              r_skp;
    logic              r_ien;
    logic              r_oen;
    logic              r_skip;   // armed by RTN/SKZ, consumed by the next instruction

    // Commit-edge next values
    logic [DATA_W-1:0] w_lu_rr;
    logic [DATA_W-1:0] w_rr_nxt;
    logic [DATA_W-1:0] w_dout_nxt;
    logic              w_write_nxt;
    logic              w_flgo_nxt;
    logic              w_flgf_nxt;
    logic              w_jmp_nxt;
    logic              w_rtn_nxt;
    logic              w_skp_nxt;
    logic              w_ien_nxt;
    logic              w_oen_nxt;
    logic              w_skip_nxt;

    assign w_sample    = (r_phase == '0);
    assign w_commit    = (r_phase == LastPh);
    assign w_phase_nxt = w_commit ? '0 : r_phase + PH_W'(1);

    mc14500b_wide_lu #(
        .DATA_W (DATA_W)
    ) u_lu (
        .i_ir     (r_ir),
        .i_rr     (r_rr),
        .i_opd    (r_opd),
        .o_rr_nxt (w_lu_rr)
    );

    // Advance the instruction phase on every clock.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Capture opcode, gated operand and pending skip at the end of phase 0.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_ir  <= NOPO_INST;
            r_opd <= '0;
            r_d0  <= 1'b0;
            r_sq  <= 1'b0;
        end else if (w_sample) begin
            r_ir  <= I;
            r_opd <= r_ien ? data_in : '0;
            r_d0  <= data_in[0];
            r_sq  <= r_skip;
        end
    end

    // Execute the captured instruction; pulses start cleared and are set only by this opcode.
    always_comb begin
        w_rr_nxt    = r_rr;
        w_dout_nxt  = r_dout;
        w_write_nxt = 1'b0;
        w_flgo_nxt  = 1'b0;
        w_flgf_nxt  = 1'b0;
        w_jmp_nxt   = 1'b0;
        w_rtn_nxt   = 1'b0;
        w_skp_nxt   = 1'b0;
        w_ien_nxt   = r_ien;
        w_oen_nxt   = r_oen;
        w_skip_nxt  = 1'b0;
        if (r_sq) begin
            // Squashed: only SKP reports it; a squashed RTN/SKZ never re-arms skip.
            w_skp_nxt = 1'b1;
        end else begin
            w_rr_nxt = w_lu_rr;
            case (r_ir)
                NOPO_INST: w_flgo_nxt = 1'b1;
                STO_INST: begin
                    if (r_oen) begin
                        w_write_nxt = 1'b1;
                        w_dout_nxt  = r_rr;
                    end
                end
                STOC_INST: begin
                    if (r_oen) begin
                        w_write_nxt = 1'b1;
                        w_dout_nxt  = ~r_rr;
                    end
                end
                IEN_INST:  w_ien_nxt = r_d0;
                OEN_INST:  w_oen_nxt = r_d0;
                JMP_INST:  w_jmp_nxt = 1'b1;
                RTN_INST: begin
                    w_rtn_nxt  = 1'b1;
                    w_skip_nxt = 1'b1;
                end
                SKZ_INST:  w_skip_nxt = (r_rr == '0);
                NOPF_INST: w_flgf_nxt = 1'b1;
                default:   ;
            endcase
        end
    end

    // Update every visible output together at the end of the last phase.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_rr    <= '0;
            r_dout  <= '0;
            r_write <= 1'b0;
            r_flgo  <= 1'b0;
            r_flgf  <= 1'b0;
            r_jmp   <= 1'b0;
            r_rtn   <= 1'b0;
            r_skp   <= 1'b0;
            r_ien   <= 1'b1;
            r_oen   <= 1'b1;
            r_skip  <= 1'b0;
        end else if (w_commit) begin
            r_rr    <= w_rr_nxt;
            r_dout  <= w_dout_nxt;
            r_write <= w_write_nxt;
            r_flgo  <= w_flgo_nxt;
            r_flgf  <= w_flgf_nxt;
            r_jmp   <= w_jmp_nxt;
            r_rtn   <= w_rtn_nxt;
            r_skp   <= w_skp_nxt;
            r_ien   <= w_ien_nxt;
            r_oen   <= w_oen_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    assign data_out  = r_dout;
    assign write     = r_write;
    assign RR        = r_rr;
    assign FLGO      = r_flgo;
    assign FLGF      = r_flgf;
    assign JMP       = r_jmp;
    assign RTN       = r_rtn;
    assign SKP       = r_skp;
    assign ien_out   = r_ien;
    assign oen_out   = r_oen;
    assign state_out = r_phase;

endmodule

// File: tb/tb_mc14500b_wide_icu.sv
// Directed bench for mc14500b_wide_icu: a table of instruction vectors with hand-computed
// results, plus hand-written sequences for reset, pulse hold and the 4-clock variant.
module tb_mc14500b_wide_icu;
    import mc14500b_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] I;
    logic [7:0] data_in;
    logic [7:0] data_out, RR;
    logic       write, FLGO, FLGF, JMP, RTN, SKP, ien_out, oen_out;
    logic       state_out;

    logic [3:0] I4;
    logic       din4, dout4, write4, rr4, flgo4, flgf4, jmp4, rtn4, skp4, ien4, oen4;
    logic [1:0] st4;

    mc14500b_wide_icu #(.DATA_W(8), .CYC_PER_INST(2)) u_dut (
        .clk_in(clk), .rst(rst), .I(I), .data_in(data_in), .data_out(data_out),
        .write(write), .RR(RR), .FLGO(FLGO), .FLGF(FLGF), .JMP(JMP), .RTN(RTN), .SKP(SKP),
        .ien_out(ien_out), .oen_out(oen_out), .state_out(state_out)
    );

    mc14500b_wide_icu #(.DATA_W(1), .CYC_PER_INST(4)) u_dut4 (
        .clk_in(clk), .rst(rst), .I(I4), .data_in(din4), .data_out(dout4),
        .write(write4), .RR(rr4), .FLGO(flgo4), .FLGF(flgf4), .JMP(jmp4), .RTN(rtn4),
        .SKP(skp4), .ien_out(ien4), .oen_out(oen4), .state_out(st4)
    );

    // Flags order: {write, FLGO, FLGF, JMP, RTN, SKP, IEN, OEN}
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] din;
        logic [7:0] rr;
        logic [7:0] dout;
        logic [7:0] fl;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] din,
                                input logic [7:0] rr, input logic [7:0] dout,
                                input logic [7:0] fl);
        return {op, din, rr, dout, fl};
    endfunction

    function automatic logic [23:0] bundle();
        return {RR, data_out, write, FLGO, FLGF, JMP, RTN, SKP, ien_out, oen_out};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Move to the low half of a phase-0 clock, where the next rising edge samples I.
    task automatic align_phase0();
        @(negedge clk);
        for (int g = 0; g < 4 && state_out !== 1'b0; g++) @(negedge clk);
        if (state_out !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL align_phase0: got %b, expected 0", state_out);
        end
    endtask

    // One full instruction; inputs are scrambled after sampling to show they are ignored.
    task automatic run_inst(input logic [3:0] op, input logic [7:0] d);
        align_phase0();
        I       = op;
        data_in = d;
        @(posedge clk);
        #1;
        I       = op ^ 4'h7;
        data_in = ~d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ph_seq;
        logic [7:0] seen;

        // Each row: opcode, operand, then RR, data_out, flags expected after its commit.
        vecs.push_back(mk(LD_INST,   8'hA5, 8'hA5, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(ANDC_INST, 8'h0F, 8'hA0, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(XNOR_INST, 8'hA0, 8'hFF, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(IEN_INST,  8'h00, 8'hFF, 8'h00, 8'b0000_0001));
        vecs.push_back(mk(LD_INST,   8'hFF, 8'h00, 8'h00, 8'b0000_0001));
        vecs.push_back(mk(IEN_INST,  8'h01, 8'h00, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(LDC_INST,  8'h3C, 8'hC3, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'h5A, 8'h5A, 8'h00, 8'b0000_0011));
        vecs.push_back(mk(STOC_INST, 8'h00, 8'h5A, 8'hA5, 8'b1000_0011));
        vecs.push_back(mk(OEN_INST,  8'h00, 8'h5A, 8'hA5, 8'b0000_0010));
        vecs.push_back(mk(STO_INST,  8'h00, 8'h5A, 8'hA5, 8'b0000_0010));
        vecs.push_back(mk(OEN_INST,  8'h01, 8'h5A, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'h00, 8'h00, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(SKZ_INST,  8'h00, 8'h00, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'hFF, 8'h00, 8'hA5, 8'b0000_0111));
        vecs.push_back(mk(RTN_INST,  8'h00, 8'h00, 8'hA5, 8'b0000_1011));
        vecs.push_back(mk(NOPO_INST, 8'h00, 8'h00, 8'hA5, 8'b0000_0111));
        vecs.push_back(mk(JMP_INST,  8'h00, 8'h00, 8'hA5, 8'b0001_0011));
        vecs.push_back(mk(NOPO_INST, 8'h00, 8'h00, 8'hA5, 8'b0100_0011));
        vecs.push_back(mk(NOPO_INST, 8'h00, 8'h00, 8'hA5, 8'b0100_0011));
        vecs.push_back(mk(NOPF_INST, 8'h00, 8'h00, 8'hA5, 8'b0010_0011));
        vecs.push_back(mk(OR_INST,   8'h0F, 8'h0F, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(ORC_INST,  8'h30, 8'hCF, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(AND_INST,  8'h5C, 8'h4C, 8'hA5, 8'b0000_0011));
        vecs.push_back(mk(STO_INST,  8'h00, 8'h4C, 8'h4C, 8'b1000_0011));
        vecs.push_back(mk(SKZ_INST,  8'h00, 8'h4C, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(LDC_INST,  8'h00, 8'hFF, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'h00, 8'h00, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(SKZ_INST,  8'h00, 8'h00, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(RTN_INST,  8'h00, 8'h00, 8'h4C, 8'b0000_0111));
        vecs.push_back(mk(LD_INST,   8'h11, 8'h11, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'h80, 8'h80, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(SKZ_INST,  8'h00, 8'h80, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(LD_INST,   8'h22, 8'h22, 8'h4C, 8'b0000_0011));
        vecs.push_back(mk(OEN_INST,  8'h00, 8'h22, 8'h4C, 8'b0000_0010));
        vecs.push_back(mk(IEN_INST,  8'h00, 8'h22, 8'h4C, 8'b0000_0000));
        vecs.push_back(mk(OEN_INST,  8'h01, 8'h22, 8'h4C, 8'b0000_0001));
        vecs.push_back(mk(LDC_INST,  8'h5A, 8'hFF, 8'h4C, 8'b0000_0001));
        vecs.push_back(mk(IEN_INST,  8'hFF, 8'hFF, 8'h4C, 8'b0000_0011));

        // Reset held from time zero, checked mid-phase.
        rst     = 1'b0;
        I       = LD_INST;
        data_in = 8'hFF;
        I4      = NOPO_INST;
        din4    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", {8'h00, bundle()}, {8'h00, 8'h00, 8'h00, 8'b0000_0011});
        check("reset_phase", {31'd0, state_out}, 32'd0);
        check("reset_dut4", {18'd0, rr4, dout4, write4, flgo4, flgf4, jmp4, rtn4, skp4,
                             ien4, oen4, st4}, {18'd0, 12'b0000_0000_1100});
        rst = 1'b1;

        // Phase must cycle 0,1,0,1 after release.
        ph_seq[3] = state_out;
        for (int k = 2; k >= 0; k--) begin
            @(negedge clk);
            #1;
            ph_seq[k] = state_out;
        end
        check("phase_cycle", {28'd0, ph_seq}, {28'd0, 4'b0101});

        // Table-driven instruction stream.
        foreach (vecs[k]) begin
            run_inst(vecs[k].op, vecs[k].din);
            check($sformatf("vec%0d_op%h", k, vecs[k].op), {8'h00, bundle()},
                  {8'h00, vecs[k].rr, vecs[k].dout, vecs[k].fl});
        end

        // Store strobe holds for a full instruction period, then clears.
        run_inst(LD_INST, 8'h5A);
        run_inst(STOC_INST, 8'h00);
        check("stoc_commit", {23'd0, write, data_out}, {23'd0, 1'b1, 8'hA5});
        I = NOPO_INST;
        @(posedge clk);
        #1;
        check("stoc_hold", {23'd0, write, data_out}, {23'd0, 1'b1, 8'hA5});
        @(posedge clk);
        #1;
        check("stoc_clear", {22'd0, write, data_out, FLGO}, {22'd0, 1'b0, 8'hA5, 1'b1});
        // Second NOPO back to back: FLGO stays high across both periods.
        @(posedge clk);
        #1;
        check("flgo_mid", {31'd0, FLGO}, 32'd1);
        @(posedge clk);
        #1;
        check("flgo_b2b", {31'd0, FLGO}, 32'd1);

        // Reset in the middle of an instruction aborts it.
        align_phase0();
        I       = LD_INST;
        data_in = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid", {7'd0, bundle(), state_out}, {7'd0, 8'h00, 8'h00, 8'b0000_0011, 1'b0});
        @(posedge clk);
        #1;
        check("rst_mid_phase", {31'd0, state_out}, 32'd0);
        rst = 1'b1;
        run_inst(NOPF_INST, 8'h00);
        check("after_rst_nopf", {8'h00, bundle()}, {8'h00, 8'h00, 8'h00, 8'b0010_0011});

        // CYC_PER_INST=4: FLGF visible 4 clocks after phase 0 starts, lasting 4 clocks.
        @(negedge clk);
        for (int g = 0; g < 8 && st4 !== 2'd0; g++) @(negedge clk);
        if (st4 !== 2'd0) begin
            n_tests++;
            n_fail++;
            $display("FAIL align_dut4: got %0d, expected 0", st4);
        end
        I4 = NOPF_INST;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            seen[k] = flgf4;
            if (k == 0) I4 = NOPO_INST ^ 4'h5;
            if (k == 3) begin
                I4   = LD_INST;
                din4 = 1'b1;
            end
        end
        check("flgf4_timing", {24'd0, seen}, {24'd0, 8'b0111_1000});
        check("rr4_ld", {31'd0, rr4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
